// File: rtl/ram_pkg.sv
// ---------------------------------------------------------------------------
// Package: ram_pkg
// Purpose:
//     Shared types and constants for the RAM read-stream engine. Holds the
//     reader state encoding, the output buffer depth and the helper that
//     decides whether another RAM read may be launched without risking an
//     output buffer overflow.
// Contents:
//     rd_state_t      reader FSM state encoding
//     BUF_DEPTH       entries in the output skid buffer
//     OCC_WIDTH       width of the buffer occupancy count
//     slot_available  issue-permission helper
// ---------------------------------------------------------------------------
package ram_pkg;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_READ,
        RD_DRAIN,
        RD_DONE
    } rd_state_t;

    localparam int BUF_DEPTH = 2;
    localparam int OCC_WIDTH = $clog2(BUF_DEPTH + 1);

    // A new read may launch only if every word already committed (sitting in
    // the buffer or still coming out of the RAM), less the word leaving this
    // cycle, leaves room for one more. A pop is only possible when the buffer
    // holds a word, so the subtraction never underflows.
    function automatic logic slot_available(
        input logic [OCC_WIDTH-1:0] occupancy,
        input logic                 inflight,
        input logic                 pop
    );
        logic [OCC_WIDTH:0] w_committed;
        w_committed = {1'b0, occupancy}
                    + {{OCC_WIDTH{1'b0}}, inflight}
                    - {{OCC_WIDTH{1'b0}}, pop};
        return (w_committed < (OCC_WIDTH + 1)'(BUF_DEPTH));
    endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// ---------------------------------------------------------------------------
// Module: stream_skid_buf
// Purpose:
//     Two-entry FIFO holding {last, data} words returned by the RAM. It soaks
//     up the one-cycle read latency so that the reader can keep issuing reads
//     while the downstream consumer applies backpressure. The head entry is
//     presented directly, so data and last hold steady while stalled.
// Ports:
//     clk          in   clock, all state on rising edge
//     rst_n        in   asynchronous active-low reset
//     i_push       in   write a word this cycle
//     i_push_data  in   word to write
//     i_push_last  in   word is the final beat of its burst
//     o_valid      out  buffer non-empty
//     i_ready      in   consumer accepts the head word
//     o_data       out  head word
//     o_last       out  head word is the final beat
//     o_occupancy  out  number of stored words (0..2)
// ---------------------------------------------------------------------------
module stream_skid_buf
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_push_last,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_last,
    output logic [OCC_WIDTH-1:0]  o_occupancy
);

    logic [DATA_WIDTH-1:0] r_data [0:BUF_DEPTH-1];
    logic                  r_last [0:BUF_DEPTH-1];
    logic                  r_rdPtr;
    logic                  r_wrPtr;
    logic [OCC_WIDTH-1:0]  r_count;
    logic                  w_pop;

    assign o_valid     = (r_count != '0);
    assign w_pop       = o_valid & i_ready;
    assign o_data      = r_data[r_rdPtr];
    assign o_last      = r_last[r_rdPtr];
    assign o_occupancy = r_count;

    // Storage and pointers. Entries are cleared on reset so the head word
    // reads as zero while the buffer is empty after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_data[i] <= '0;
                r_last[i] <= 1'b0;
            end
            r_rdPtr <= 1'b0;
            r_wrPtr <= 1'b0;
        end else begin
            if (i_push) begin
                r_data[r_wrPtr] <= i_push_data;
                r_last[r_wrPtr] <= i_push_last;
                r_wrPtr         <= ~r_wrPtr;
            end
            if (w_pop) begin
                r_rdPtr <= ~r_rdPtr;
            end
        end
    end

    // Occupancy count; a simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + OCC_WIDTH'(1);
                2'b01:   r_count <= r_count - OCC_WIDTH'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ram_stream_reader.sv
// ---------------------------------------------------------------------------
// Module: ram_stream_reader
// Purpose:
//     Read-side engine for a simple dual-port RAM with a one-cycle registered
//     read. A burst request (base address, length) walks the RAM read port
//     and delivers the words as a valid/ready stream whose final beat carries
//     a last marker. Reads are throttled so the two-entry output buffer can
//     never overflow, which makes full backpressure lossless.
// Ports:
//     clk         in   clock, all state on rising edge
//     rst_n       in   asynchronous active-low reset
//     start       in   burst request, sampled only while idle
//     base_addr   in   first RAM address of the burst
//     length      in   word count, 0..2**ADDR_WIDTH
//     busy        out  burst in progress (READ, DRAIN, DONE)
//     done        out  one-cycle pulse while the burst completes
//     mem_addr_r  out  RAM read address
//     mem_dout    in   RAM read data, valid one cycle after the address
//     m_valid     out  stream valid
//     m_ready     in   stream ready
//     m_data      out  stream word
//     m_last      out  final beat of the burst
// ---------------------------------------------------------------------------
module ram_stream_reader
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_addr_r,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   REM_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0]   REM_ZERO = '0;

    rd_state_t             r_state;
    rd_state_t             w_nextState;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   r_remaining;
    logic                  r_inflight;
    logic                  r_inflightLast;

    logic                  w_busy;
    logic                  w_done;
    logic                  w_accept;
    logic                  w_issue;
    logic                  w_issueLast;
    logic                  w_pop;
    logic                  w_valid;
    logic                  w_bufLast;
    logic [DATA_WIDTH-1:0] w_bufData;
    logic [OCC_WIDTH-1:0]  w_occupancy;

    assign w_accept    = (r_state == RD_IDLE) && start && (length != REM_ZERO);
    assign w_pop       = w_valid & m_ready;

    // A read launches only while words remain and the buffer, counting the
    // word still on its way out of the RAM, has room for it.
    assign w_issue     = (r_state == RD_READ)
                      && (r_remaining != REM_ZERO)
                      && slot_available(w_occupancy, r_inflight, w_pop);
    assign w_issueLast = w_issue && (r_remaining == REM_ONE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RD_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and status decode. A zero-length request goes straight to
    // DONE so it still produces a completion pulse but no beats.
    always_comb begin
        w_nextState = r_state;
        w_busy      = 1'b1;
        w_done      = 1'b0;
        case (r_state)
            RD_IDLE: begin
                w_busy = 1'b0;
                if (start) begin
                    w_nextState = (length != REM_ZERO) ? RD_READ : RD_DONE;
                end
            end
            RD_READ: begin
                if (w_issueLast) begin
                    w_nextState = RD_DRAIN;
                end
            end
            RD_DRAIN: begin
                if (w_pop && w_bufLast) begin
                    w_nextState = RD_DONE;
                end
            end
            RD_DONE: begin
                w_done      = 1'b1;
                w_nextState = RD_IDLE;
            end
            default: begin
                w_nextState = RD_IDLE;
            end
        endcase
    end

    // Address and remaining-count registers. The address wraps naturally at
    // the top of the RAM, so a burst may straddle the end of memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_remaining <= '0;
        end else if (w_accept) begin
            r_addr      <= base_addr;
            r_remaining <= length;
        end else if (w_issue) begin
            r_addr      <= r_addr + ADDR_ONE;
            r_remaining <= r_remaining - REM_ONE;
        end
    end

    // In-flight tracking: the RAM returns the word one edge after the issue,
    // so this flag (and the last tag that travels with it) marks exactly the
    // cycles in which mem_dout must be captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight     <= 1'b0;
            r_inflightLast <= 1'b0;
        end else begin
            r_inflight     <= w_issue;
            r_inflightLast <= w_issueLast;
        end
    end

    stream_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (r_inflight),
        .i_push_data (mem_dout),
        .i_push_last (r_inflightLast),
        .o_valid     (w_valid),
        .i_ready     (m_ready),
        .o_data      (w_bufData),
        .o_last      (w_bufLast),
        .o_occupancy (w_occupancy)
    );

    assign busy       = w_busy;
    assign done       = w_done;
    assign mem_addr_r = r_addr;
    assign m_valid    = w_valid;
    assign m_data     = w_bufData;
    assign m_last     = w_bufLast;

endmodule

// File: tb/tb_ram_stream_reader.sv
// ---------------------------------------------------------------------------
// Testbench: tb_ram_stream_reader
// Purpose:
//     Directed bench for ram_stream_reader. A registered-read RAM model
//     preloaded with mem[i] = i[7:0] sits on the read port, so every beat's
//     expected value is simply the low byte of its address.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ram_stream_reader;

    logic        clk;
    logic        rst_n;
    logic        startReq;
    logic [9:0]  baseAddr;
    logic [10:0] burstLen;
    logic        busy;
    logic        done;
    logic [9:0]  memAddrR;
    logic [7:0]  ramDout;
    logic        mValid;
    logic        mReady;
    logic [7:0]  mData;
    logic        mLast;

    logic [7:0]  ramMem [0:1023];

    int          checkCount = 0;
    int          passCount  = 0;

    ram_stream_reader #(
        .ADDR_WIDTH (10),
        .DATA_WIDTH (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (startReq),
        .base_addr  (baseAddr),
        .length     (burstLen),
        .busy       (busy),
        .done       (done),
        .mem_addr_r (memAddrR),
        .mem_dout   (ramDout),
        .m_valid    (mValid),
        .m_ready    (mReady),
        .m_data     (mData),
        .m_last     (mLast)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Read port of the simple dual-port RAM: one-cycle registered read.
    always @(posedge clk) begin
        ramDout <= ramMem[memAddrR];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    // Present a burst request for exactly one accepting edge.
    task automatic applyStimulus(input logic [9:0] base, input logic [10:0] len);
        startReq = 1'b1;
        baseAddr = base;
        burstLen = len;
        tick();
        startReq = 1'b0;
    endtask

    // Consume one burst starting the cycle after acceptance. readyMode:
    // 0 = always ready, 1 = repeating 1-0-0-1, 2 = random. With checkTiming
    // the full-throughput addresses, first-valid cycle and done cycle are
    // checked as well.
    task automatic collectBurst(input string tag, input int base, input int len,
                                input int readyMode, input bit checkTiming);
        int         c;
        int         beats;
        int         doneCount;
        int         budget;
        bit         finished;
        bit         prevStall;
        logic [7:0] prevData;
        logic       prevLast;
        c         = 0;
        beats     = 0;
        doneCount = 0;
        finished  = 1'b0;
        prevStall = 1'b0;
        prevData  = '0;
        prevLast  = 1'b0;
        budget    = len * 6 + 50;
        while (!finished && c < budget) begin
            case (readyMode)
                0:       mReady = 1'b1;
                1:       mReady = ((c % 4) == 0) || ((c % 4) == 3);
                default: mReady = 1'($urandom_range(0, 1));
            endcase
            if (prevStall) begin
                checkOutput({tag, " stall valid"}, 32'(mValid), 32'd1);
                checkOutput({tag, " stall data"}, 32'(mData), 32'(prevData));
                checkOutput({tag, " stall last"}, 32'(mLast), 32'(prevLast));
            end
            if (checkTiming && c < len) begin
                checkOutput({tag, " addr"}, 32'(memAddrR), 32'((base + c) % 1024));
            end
            if (checkTiming && len > 0 && c <= 2) begin
                checkOutput({tag, " first valid"}, 32'(mValid), 32'(c == 2));
            end
            if (mValid && mReady) begin
                checkOutput({tag, " data"}, 32'(mData), 32'((base + beats) & 8'hFF));
                checkOutput({tag, " last"}, 32'(mLast), 32'(beats == len - 1));
                beats++;
            end
            if (done) begin
                doneCount++;
                finished = 1'b1;
                if (checkTiming) begin
                    checkOutput({tag, " done cycle"}, 32'(c), 32'((len == 0) ? 0 : len + 2));
                end
            end
            prevStall = mValid && !mReady;
            prevData  = mData;
            prevLast  = mLast;
            tick();
            c++;
        end
        checkOutput({tag, " beat count"}, 32'(beats), 32'(len));
        checkOutput({tag, " done pulses"}, 32'(doneCount), 32'd1);
        mReady = 1'b1;
        checkOutput({tag, " done low after"}, 32'(done), 32'd0);
        checkOutput({tag, " idle after"}, 32'(busy), 32'd0);
        checkOutput({tag, " no extra beat"}, 32'(mValid), 32'd0);
    endtask

    // Directed sequence: reset, plain burst, wrap, backpressure, zero length
    // with ignored start, mid-burst reset, full-memory burst.
    initial begin
        for (int i = 0; i < 1024; i++) begin
            ramMem[i] = i[7:0];
        end
        rst_n    = 1'b0;
        startReq = 1'b0;
        baseAddr = '0;
        burstLen = '0;
        mReady   = 1'b0;
        tick();
        tick();

        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset m_valid", 32'(mValid), 32'd0);
        checkOutput("reset m_last", 32'(mLast), 32'd0);
        checkOutput("reset m_data", 32'(mData), 32'd0);
        checkOutput("reset mem_addr_r", 32'(memAddrR), 32'd0);
        rst_n = 1'b1;
        tick();

        $display("[TB] burst base=010 len=4");
        applyStimulus(10'h010, 11'd4);
        collectBurst("b010", 32'h010, 4, 0, 1'b1);

        $display("[TB] wrap burst base=3FE len=4");
        applyStimulus(10'h3FE, 11'd4);
        collectBurst("wrap", 32'h3FE, 4, 0, 1'b1);

        $display("[TB] backpressure bursts len=8");
        applyStimulus(10'h040, 11'd8);
        collectBurst("bp1001", 32'h040, 8, 1, 1'b0);
        applyStimulus(10'h0F9, 11'd8);
        collectBurst("bprand", 32'h0F9, 8, 2, 1'b0);

        $display("[TB] zero length and start while busy");
        applyStimulus(10'h055, 11'd0);
        collectBurst("len0", 32'h055, 0, 0, 1'b1);
        applyStimulus(10'h020, 11'd3);
        startReq = 1'b1;
        baseAddr = 10'h100;
        burstLen = 11'd5;
        mReady   = 1'b0;
        tick();
        tick();
        checkOutput("busy start addr", 32'(memAddrR), 32'h022);
        checkOutput("busy start busy", 32'(busy), 32'd1);
        startReq = 1'b0;
        collectBurst("ignored", 32'h020, 3, 0, 1'b0);

        $display("[TB] reset mid-burst");
        applyStimulus(10'h080, 11'd6);
        mReady = 1'b0;
        tick();
        tick();
        tick();
        checkOutput("pre-reset m_valid", 32'(mValid), 32'd1);
        checkOutput("pre-reset m_data", 32'(mData), 32'h80);
        checkOutput("pre-reset busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async m_valid", 32'(mValid), 32'd0);
        checkOutput("async busy", 32'(busy), 32'd0);
        checkOutput("async m_last", 32'(mLast), 32'd0);
        checkOutput("async m_data", 32'(mData), 32'd0);
        checkOutput("async mem_addr_r", 32'(memAddrR), 32'd0);
        tick();
        checkOutput("in-reset done", 32'(done), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        applyStimulus(10'h000, 11'd2);
        collectBurst("post-reset", 32'h000, 2, 0, 1'b1);

        $display("[TB] full memory burst len=1024");
        applyStimulus(10'h000, 11'd1024);
        collectBurst("full", 32'h000, 1024, 0, 1'b1);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
